// File: rtl/clk_chain_pkg.sv
// Shared types and constants for the seconds/minute/hour counter chain.
package clk_chain_pkg;

  localparam int WIDTH   = 6;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_WAIT  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  // A seconds wrap is only the exact step from the terminal value to zero.
  function automatic logic is_wrap(input logic [WIDTH-1:0] prev,
                                   input logic [WIDTH-1:0] cur,
                                   input logic [WIDTH-1:0] term);
    return (prev == term) && (cur == '0);
  endfunction

endpackage

// File: rtl/fsm_minute_if.sv
// Signal bundle between the seconds stage / controller and the minute stage.
interface fsm_minute_if;
  import clk_chain_pkg::*;

  // No valid/ready here: sec_in is a level sampled every clock, min_in_load is a
  // one-clock strobe qualifying min_in, and all outputs are registered levels.
  logic [WIDTH-1:0] sec_in;
  logic [WIDTH-1:0] min_in;
  logic             min_in_load;
  logic [WIDTH-1:0] min_out;
  logic             hour_tick;
  logic             running;
  state_t           state_dbg;

  modport master (
    output sec_in, min_in, min_in_load,
    input  min_out, hour_tick, running, state_dbg
  );

  modport slave (
    input  sec_in, min_in, min_in_load,
    output min_out, hour_tick, running, state_dbg
  );

endinterface

// File: rtl/mod_n_counter.sv
// Loadable modulo-(MAX+1) counter with a registered wrap pulse; shared by minute and hour stages.
module mod_n_counter #(
  parameter int WIDTH = 6,
  parameter int MAX   = 59
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             wrap_pulse
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      // Load wins over increment and never produces a wrap pulse.
      if (load) begin
        count <= (load_val <= MAX_V) ? load_val : '0;
      end else if (inc) begin
        if (count == MAX_V) begin
          count      <= '0;
          wrap_pulse <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fsm_minute.sv
// Minute stage: detects seconds wraps, sequences load/run, and drives the hour carry.
module fsm_minute
  import clk_chain_pkg::*;
#(
  parameter int SEC_MAX_P = SEC_MAX,
  parameter int MIN_MAX_P = MIN_MAX
) (
  input  logic               clk,
  input  logic               rst,
  fsm_minute_if.slave        bus
);

  localparam logic [WIDTH-1:0] SEC_TERM = WIDTH'(SEC_MAX_P);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sec_prev;
  logic             wrap;
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_load_val;
  logic             cnt_inc;
  logic             running_q;

  assign wrap = is_wrap(sec_prev, bus.sec_in, SEC_TERM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RESET;
      sec_prev  <= '0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sec_prev  <= bus.sec_in;
      running_q <= (state_d == S_RUN);
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = bus.min_in;
    cnt_inc      = 1'b0;
    case (state_q)
      S_RESET: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.min_in_load) begin
          cnt_load = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.min_in_load) cnt_load = 1'b1;
        else if (wrap)       cnt_inc  = 1'b1;
      end
      default: begin
        // Unused code: recover through reset and clear the count.
        state_d      = S_RESET;
        cnt_load     = 1'b1;
        cnt_load_val = '0;
      end
    endcase
  end

  mod_n_counter #(
    .WIDTH (WIDTH),
    .MAX   (MIN_MAX_P)
  ) u_min_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .load_val   (cnt_load_val),
    .inc        (cnt_inc),
    .count      (bus.min_out),
    .wrap_pulse (bus.hour_tick)
  );

  assign bus.running   = running_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_fsm_minute.sv
// Randomized and directed bench for fsm_minute against a behavioural minute-clock model.
module tb_fsm_minute;
  import clk_chain_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fsm_minute_if bus();

  fsm_minute dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: phase 0 = resetting, 1 = waiting for a load, 2 = running.
  int m_phase = 0;
  int m_min   = 0;
  int m_tick  = 0;
  int m_prev  = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(input int v);
    return (v <= MIN_MAX) ? v : 0;
  endfunction

  task automatic model_edge(input bit r, input int sec, input bit ld, input int val);
    if (r) begin
      m_phase = 0; m_min = 0; m_tick = 0; m_prev = 0;
    end else begin
      m_tick = 0;
      if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1) begin
        if (ld) begin m_min = clamp(val); m_phase = 2; end
      end else begin
        if (ld) m_min = clamp(val);
        else if (m_prev == SEC_MAX && sec == 0) begin
          m_tick = (m_min == MIN_MAX) ? 1 : 0;
          m_min  = (m_min + 1) % (MIN_MAX + 1);
        end
      end
      m_prev = sec;
    end
    exp_q.push_back(WIDTH'(m_min));
  endtask

  task automatic step(input bit r, input int sec, input bit ld, input int val);
    logic [WIDTH-1:0] exp_min;
    state_t exp_state;
    @(negedge clk);
    rst             = r;
    bus.sec_in      = WIDTH'(sec);
    bus.min_in_load = ld;
    bus.min_in      = WIDTH'(val);
    @(posedge clk);
    model_edge(r, sec, ld, val);
    #1;
    exp_min = exp_q.pop_front();
    exp_state = (m_phase == 0) ? S_RESET : (m_phase == 1) ? S_WAIT : S_RUN;
    check("min_out",   int'(bus.min_out),   int'(exp_min));
    check("hour_tick", int'(bus.hour_tick), m_tick);
    check("running",   int'(bus.running),   (m_phase == 2) ? 1 : 0);
    check("state",     int'(bus.state_dbg), int'(exp_state));
  endtask

  initial begin
    int sc;
    rst = 1'b1; bus.sec_in = '0; bus.min_in = '0; bus.min_in_load = 1'b0;

    // Reset and first load
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    check("reset_min", int'(bus.min_out), 0);
    check("reset_state", int'(bus.state_dbg), int'(S_RESET));
    step(0, 0, 0, 0);
    check("after_reset_wait", int'(bus.state_dbg), int'(S_WAIT));
    step(0, 0, 1, 5);
    check("load5", int'(bus.min_out), 5);

    // Plain advance
    step(0, 57, 0, 0); step(0, 58, 0, 0); step(0, 59, 0, 0); step(0, 0, 0, 0);
    check("advance6", int'(bus.min_out), 6);
    step(0, 1, 0, 0);

    // Wrap with carry
    step(0, 1, 1, 59); step(0, 59, 0, 0); step(0, 0, 0, 0);
    check("carry_tick", int'(bus.hour_tick), 1);
    check("carry_min", int'(bus.min_out), 0);
    step(0, 1, 0, 0);
    check("carry_one_cycle", int'(bus.hour_tick), 0);

    // Held 59 then a jump: no advance
    for (int i = 0; i < 4; i++) step(0, 59, 0, 0);
    step(0, 3, 0, 0);
    check("held59", int'(bus.min_out), 0);

    // Wrap ignored while waiting
    step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 59, 0, 0); step(0, 0, 0, 0);
    check("wait_ignores_wrap", int'(bus.min_out), 0);

    // Clamp and load priority over wrap
    step(0, 1, 1, 63);
    check("clamp63", int'(bus.min_out), 0);
    step(0, 1, 1, 59); step(0, 59, 0, 0); step(0, 0, 1, 10);
    check("load_over_wrap", int'(bus.min_out), 10);
    check("load_no_tick", int'(bus.hour_tick), 0);

    // Reset coincident with a wrap
    step(0, 1, 1, 42); step(0, 59, 0, 0); step(1, 0, 0, 0);
    check("midrun_reset", int'(bus.min_out), 0);
    step(0, 1, 0, 0); step(0, 2, 0, 0);

    // Randomized traffic
    sc = 0;
    for (int i = 0; i < 3000; i++) begin
      int r, rr, val;
      bit ld, rs;
      r = $urandom_range(0, 99);
      if (r < 85)      sc = (sc + 1) % (SEC_MAX + 1);
      else if (r < 92) sc = SEC_MAX;
      else             sc = $urandom_range(0, 63);
      ld  = ($urandom_range(0, 19) == 0);
      rs  = ($urandom_range(0, 299) == 0);
      rr  = $urandom_range(0, 99);
      val = (rr < 50) ? $urandom_range(55, 59) : $urandom_range(0, 63);
      step(rs, sc, ld, val);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_minute.md
Name: fsm_minute

Overview:
- Minute-counting stage that sits directly downstream of the seconds-counter stage in the clock-counter chain.
- Watches the upstream 6-bit seconds value and advances a mod-60 minute count on each seconds wrap (59 -> 0).
- Supports an explicit minute preload.
- Emits a one-cycle carry pulse for a downstream hour stage.

Parameters:
- WIDTH, 6, bit width of the seconds and minute values.
- SEC_MAX, 59, terminal seconds value whose wrap to 0 advances the minute.
- MIN_MAX, 59, terminal minute value; the count wraps to 0 after it.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sec_in  input  WIDTH  current seconds value from the upstream stage.
- min_in  input  WIDTH  preload value for the minute count.
- min_in_load  input  1  preload strobe, sampled each clock.
- min_out  output  WIDTH  current minute count (registered).
- hour_tick  output  1  one-cycle pulse on minute wrap MIN_MAX -> 0 (registered).
- running  output  1  high while in S_RUN (registered).

Behaviour:
- Reset: rst high at an edge forces state=S_RESET, min_out=0, hour_tick=0, running=0, sec_prev=0.
  - Applies mid-operation too; any pending load or advance is discarded.
- sec_prev: internal register, sec_prev <= sec_in every non-reset edge, in all states.
- Wrap event: wrap = (sec_prev == SEC_MAX) && (sec_in == 0), evaluated combinationally before the edge.
  - A held 59 never advances the minute.
  - 59 -> 1, 59 -> 59 or any other jump never advances the minute.
- States (2-bit encoding):
  - S_RESET=0: unconditionally -> S_WAIT next edge; min_out holds 0.
  - S_WAIT=1: min_out holds; wrap events are ignored.
    - On min_in_load: min_out <= clamp(min_in), -> S_RUN.
    - Otherwise stay in S_WAIT.
  - S_RUN=2: priority is min_in_load > wrap.
    - min_in_load: min_out <= clamp(min_in); stay S_RUN; hour_tick=0 even if a wrap coincides.
    - Else on wrap: if min_out == MIN_MAX then min_out <= 0 and hour_tick <= 1; else min_out <= min_out + 1.
    - Else min_out holds.
  - Code 3: illegal; -> S_RESET next edge with min_out <= 0.
- clamp(v): v if v <= MIN_MAX, else 0.
- Latency: min_out changes at the same edge at which the upstream second counter is observed as 0 after 59, i.e. 1 clock after sec_in first presents 0.
- hour_tick:
  - Default 0 every edge.
  - High for exactly one cycle, aligned with min_out becoming 0 from wrap.
  - Never set by a load.
- running <= (next state == S_RUN).
- Arithmetic: increment is WIDTH bits unsigned; no overflow is possible because of the clamp and MIN_MAX compare.

Decomposition:
- Shared package clk_chain_pkg holds:
  - state enum (S_RESET, S_WAIT, S_RUN);
  - WIDTH, SEC_MAX, MIN_MAX constants, also reused by the second and hour stages.
- One natural sub-module, mod_n_counter:
  - parameterised WIDTH/MAX;
  - inputs: load, load_val, inc;
  - outputs: count, wrap_pulse.
  - The hour stage reuses it.
- FSM and wrap detection stay in fsm_minute.

Test Plan:
- Reset and load: rst for 2 cycles, release -> cycle 1 S_RESET, then S_WAIT, min_out=0, running=0. Pulse min_in_load with min_in=5 -> min_out=5, running=1.
- Advance: in S_RUN with min_out=5, drive sec_in 57,58,59,0,1 -> min_out=6 one edge after sec_in=0 is presented; hour_tick stays 0.
- Wrap and carry: load 59, drive sec_in 59 then 0 -> min_out=0 and hour_tick=1 for exactly one cycle.
- Non-advance cases:
  - sec_in held at 59 for 4 cycles, then 3 -> min_out unchanged.
  - Wrap 59 -> 0 while in S_WAIT -> min_out unchanged.
- Load priority and clamp:
  - min_in_load with min_in=63 -> min_out=0.
  - In S_RUN with min_out=59, load min_in=10 in the same cycle as a wrap -> min_out=10, hour_tick=0.
- Reset mid-run: min_out=42 in S_RUN, assert rst for one edge coincident with a wrap -> min_out=0, hour_tick=0, state S_RESET, then S_WAIT.
